// File: rtl/lsu_load_ctrl.sv
// lsu_load_ctrl: load sequencer issuing one or two word reads per load, with merge, extension and timeout
module lsu_load_ctrl #(
    parameter bit MISALIGN_EN = 1'b1,
    parameter int TIMEOUT     = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [31:0] i_ld_addr,
    input  logic [2:0]  i_ld_sel,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_ld_done,
    output logic [31:0] o_ld_data,
    output logic        o_ld_err
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, lo_q, lo_d, data_q, data_d;
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        accept, bad_in, split_q, to_hit, last_ack;
    logic [63:0] pair;
    logic [31:0] w, ext, base;

    function automatic logic is_split(input logic [2:0] sel, input logic [1:0] off);
        return ((sel == 3'd1 || sel == 3'd4) && off == 2'd3) || (sel == 3'd2 && off != 2'd0);
    endfunction

    // Classify the request, merge the returned words and extend the selected field
    always_comb begin
        accept   = i_ld_valid && state_q == IDLE;
        bad_in   = i_ld_sel > 3'd4 || (!MISALIGN_EN && is_split(i_ld_sel, i_ld_addr[1:0]));
        split_q  = is_split(sel_q, addr_q[1:0]);
        to_hit   = !i_mem_ack && cnt_q == TO_LAST;
        last_ack = i_mem_ack && (state_q == ACC1 || (state_q == ACC0 && !split_q));
        base     = {addr_q[31:2], 2'b00};
        pair     = state_q == ACC1 ? {i_mem_rdata, lo_q} : {32'd0, i_mem_rdata};
        w        = 32'(pair >> {addr_q[1:0], 3'b000});
        ext      = sel_q == 3'd0 ? {{24{w[7]}}, w[7:0]} :
                   sel_q == 3'd1 ? {{16{w[15]}}, w[15:0]} :
                   sel_q == 3'd3 ? {24'd0, w[7:0]} :
                   sel_q == 3'd4 ? {16'd0, w[15:0]} : w;
    end

    // Next state: an ack always beats a timeout hitting in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bad_in ? DONE : ACC0;
            ACC0:    if (i_mem_ack) state_d = split_q ? ACC1 : DONE;
                     else if (to_hit) state_d = DONE;
            ACC1:    if (i_mem_ack || to_hit) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture request, low word, wait count and the final result
    always_comb begin
        addr_d = addr_q;
        sel_d  = sel_q;
        lo_d   = lo_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        err_d  = err_q;
        if (accept) begin
            addr_d = i_ld_addr;
            sel_d  = i_ld_sel;
            cnt_d  = '0;
            if (bad_in) begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end
        if (state_q == ACC0 || state_q == ACC1) begin
            cnt_d = i_mem_ack ? 8'd0 : cnt_q + 8'd1;
            if (state_q == ACC0 && i_mem_ack) lo_d = i_mem_rdata;
            if (last_ack) begin
                data_d = ext;
                err_d  = 1'b0;
            end else if (to_hit) begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end
    end

    // Outputs decoded from state; result fields come straight from their registers
    always_comb begin
        o_ld_ready = state_q == IDLE;
        o_mem_req  = state_q == ACC0 || state_q == ACC1;
        o_mem_addr = state_q == ACC0 ? base : state_q == ACC1 ? base + 32'd4 : '0;
        o_ld_done  = state_q == DONE;
        o_ld_data  = data_q;
        o_ld_err   = err_q;
    end

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
endmodule
